// File: rtl/opb_status_bank.sv
// OPB slave: C_NUM_CH live capture registers copied to read-only shadows on a CTRL SNAP write; ack one cycle after select,
// user_valid never back-pressured. Define OPB_STATUS_BANK_STICKY_EN for OR-accumulating live registers cleared by each snapshot.
module opb_status_bank #(
  parameter logic [31:0] C_BASEADDR = 32'h0108EC00,
  parameter logic [31:0] C_HIGHADDR = 32'h0108ECFF,
  parameter int          C_NUM_CH   = 4,
  parameter int          C_DWIDTH   = 32
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst_n,
  input  logic [0:31]                  OPB_ABus,
  input  logic [0:3]                   OPB_BE,
  input  logic [0:31]                  OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:31]                  Sl_DBus,
  output logic                         Sl_xferAck,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  input  logic [C_NUM_CH*C_DWIDTH-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]          user_valid
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [1:0]                         r_rst_sync;
  logic                               w_rst_n;
  logic [31:0]                        w_addr;
  logic                               w_hit;
  logic                               w_take;
  logic [31:0]                        r_off;
  logic                               r_rnw;
  logic                               r_wsnap;
  logic                               w_is_ctrl;
  logic                               w_is_cnt;
  logic                               w_is_shadow;
  logic [31:0]                        w_sh_off;
  logic                               w_ok;
  logic                               w_snap;
  logic [31:0]                        w_rdat;
  logic [15:0]                        r_snapcnt;
  logic [C_NUM_CH-1:0][C_DWIDTH-1:0]  r_live;
  logic [C_NUM_CH-1:0][C_DWIDTH-1:0]  r_shadow;
  logic                               w_unused;

  // Assertion is immediate; release passes two flops so no transfer is taken on the release edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_addr = OPB_ABus;
  assign w_hit  = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_take = (r_state == IDLE) && w_hit;

  always_ff @(posedge OPB_Clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_off   <= '0;
      r_rnw   <= 1'b0;
      r_wsnap <= 1'b0;
    end else if (w_take) begin
      r_off   <= w_addr - C_BASEADDR;
      r_rnw   <= OPB_RNW;
      r_wsnap <= OPB_DBus[31];
    end
  end

  assign w_is_ctrl   = (r_off == 32'd0);
  assign w_is_cnt    = (r_off == 32'd4);
  assign w_sh_off    = r_off - 32'd16;
  assign w_is_shadow = (r_off >= 32'd16) && (r_off < 32'(16 + 4 * C_NUM_CH)) && (r_off[1:0] == 2'b00);
  assign w_ok        = r_rnw ? (w_is_cnt || w_is_shadow) : w_is_ctrl;
  assign w_snap      = (r_state == ACK) && !r_rnw && w_is_ctrl && r_wsnap;

  always_comb begin
    w_rdat = '0;
    if (w_is_cnt) w_rdat[15:0] = r_snapcnt;
    for (int i = 0; i < C_NUM_CH; i++) begin
      if (w_is_shadow && (w_sh_off[31:2] == 30'(i))) w_rdat[C_DWIDTH-1:0] = r_shadow[i];
    end
  end

  always_ff @(posedge OPB_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
`ifdef OPB_STATUS_BANK_STICKY_EN
        // A capture coinciding with a snapshot starts the next accumulation window.
        if (user_valid[i])
          r_live[i] <= w_snap ? user_data_in[i*C_DWIDTH +: C_DWIDTH]
                              : (r_live[i] | user_data_in[i*C_DWIDTH +: C_DWIDTH]);
        else if (w_snap)
          r_live[i] <= '0;
`else
        if (user_valid[i]) r_live[i] <= user_data_in[i*C_DWIDTH +: C_DWIDTH];
`endif
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shadow  <= '0;
      r_snapcnt <= '0;
    end else if (w_snap) begin
      r_shadow  <= r_live;
      r_snapcnt <= r_snapcnt + 16'd1;
    end
  end

  assign Sl_xferAck = (r_state == ACK) && w_ok;
  assign Sl_errAck  = (r_state == ACK) && !w_ok;
  assign Sl_DBus    = (Sl_xferAck && r_rnw) ? w_rdat : 32'h0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_unused = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:30]};

endmodule

// File: tb/tb_opb_status_bank.sv
// Randomized and directed bench for opb_status_bank with a transaction-level reference model.
module tb_opb_status_bank;
  localparam int          N     = 4;
  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'h0108EC00;
  localparam logic [31:0] HIGH  = 32'h0108ECFF;
  localparam logic [31:0] DMASK = 32'hFFFF_FFFF >> (32 - DW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   abus = '0;
  logic [3:0]    be = 4'hF;
  logic [31:0]   dbus = '0;
  logic          rnw_i = 1'b0;
  logic          sel = 1'b0;
  logic          seq = 1'b0;
  logic [N*DW-1:0] udata = '0;
  logic [N-1:0]  valid = '0;
  logic [31:0]   Sl_DBus;
  logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;

  int total = 0;
  int bad = 0;

  opb_status_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_CH(N), .C_DWIDTH(DW)) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw_i), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(udata), .user_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_live [N];
  logic [31:0] m_sh [N];
  int          m_cnt = 0;
  int          m_since = 0;
  bit          m_pend = 0, m_ok = 0, m_rnw = 0, m_wbit = 0, m_snap = 0;
  logic [31:0] m_rdat = '0, m_off = '0, m_d = '0;

  function automatic bit m_legal(input logic [31:0] off, input bit rnw);
    if (!rnw) return off == 0;
    if (off == 4) return 1'b1;
    return (off >= 16) && (off < 16 + 4 * N) && (off % 4 == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_since = 0; m_pend = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) begin m_live[i] = '0; m_sh[i] = '0; end
    end else begin
      if (m_since < 3) m_since++;
      if (m_since >= 3) begin
        m_snap = m_pend && m_ok && !m_rnw && m_wbit;
        if (m_snap) begin
          m_sh = m_live;
          m_cnt = (m_cnt + 1) % 65536;
        end
        for (int i = 0; i < N; i++) begin
          m_d = udata[i*DW +: DW] & DMASK;
`ifdef OPB_STATUS_BANK_STICKY_EN
          if (valid[i]) m_live[i] = m_snap ? m_d : (m_live[i] | m_d);
          else if (m_snap) m_live[i] = '0;
`else
          if (valid[i]) m_live[i] = m_d;
`endif
        end
        if (m_pend) m_pend = 0;
        else if (sel && abus >= BASE && abus <= HIGH) begin
          m_pend = 1;
          m_off  = abus - BASE;
          m_rnw  = rnw_i;
          m_wbit = dbus[0];
          m_ok   = m_legal(m_off, rnw_i);
          if (!(m_ok && rnw_i)) m_rdat = '0;
          else if (m_off == 4) m_rdat = 32'(m_cnt);
          else m_rdat = m_sh[(m_off - 16) / 4];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit c_ex, c_ee;
  always @(negedge clk) begin
    c_ex = rst_n && m_pend && m_ok;
    c_ee = rst_n && m_pend && !m_ok;
    chk("cyc_ack", {30'b0, Sl_xferAck, Sl_errAck}, {30'b0, c_ex, c_ee});
    chk("cyc_dbus", Sl_DBus, (c_ex && m_rnw) ? m_rdat : 32'h0);
    chk("cyc_tie", {30'b0, Sl_retry, Sl_toutSup}, 32'h0);
  end

  // ---------------- directed helpers ----------------
  task automatic xfer(input logic [31:0] a, input bit rnw, input logic [31:0] d,
                      input logic [N-1:0] cv, input logic [N*DW-1:0] cd,
                      output logic [31:0] rd, output logic [2:0] flags);
    @(negedge clk);
    abus = a; rnw_i = rnw; dbus = d; sel = 1'b1; valid = '0;
    @(negedge clk);
    rd = Sl_DBus; flags[2] = Sl_xferAck; flags[1] = Sl_errAck;
    sel = 1'b0; valid = cv; udata = cd;
    @(negedge clk);
    flags[0] = Sl_xferAck | Sl_errAck;
    valid = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd; logic [2:0] fl;
    xfer(BASE + off, 1'b1, 32'h0, '0, '0, rd, fl);
    chk({nm, "_ack"}, {29'b0, fl}, 32'b100);
    chk({nm, "_data"}, rd, exp);
  endtask

  task automatic snap(input string nm, input logic [N-1:0] cv, input logic [N*DW-1:0] cd);
    logic [31:0] rd; logic [2:0] fl;
    xfer(BASE, 1'b0, 32'h1, cv, cd, rd, fl);
    chk({nm, "_ack"}, {29'b0, fl}, 32'b100);
  endtask

  task automatic resp_chk(input string nm, input logic [31:0] a, input bit rnw, input logic [2:0] exp);
    logic [31:0] rd; logic [2:0] fl;
    xfer(a, rnw, 32'h1, '0, '0, rd, fl);
    chk({nm, "_ack"}, {29'b0, fl}, {29'b0, exp});
    chk({nm, "_data"}, rd, 32'h0);
  endtask

  task automatic capture(input int ch, input logic [31:0] d);
    @(negedge clk);
    udata = '0; udata[ch*DW +: DW] = d; valid = '0; valid[ch] = 1'b1;
    @(negedge clk);
    valid = '0;
  endtask

  int acks, need, cyc;
  logic [N*DW-1:0] cd;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'b0, Sl_xferAck, Sl_errAck}, 32'h0);
    chk("rst_dbus", Sl_DBus, 32'h0);

    // release with a request already pending
    abus = BASE + 4; rnw_i = 1'b1; sel = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("sync_edge1", {30'b0, Sl_xferAck, Sl_errAck}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("sync_first_ack", {30'b0, Sl_xferAck, Sl_errAck}, 32'b10);
    sel = 1'b0;

    capture(0, 32'hA5A5_0001);
    snap("snap1", '0, '0);
    rd_chk("shadow0", 32'h10, 32'hA5A5_0001);
    rd_chk("cnt1", 32'h04, 32'h0001);

    begin
      logic [31:0] rd; logic [2:0] fl;
      xfer(BASE, 1'b0, 32'h2, '0, '0, rd, fl);
      chk("ctrl_nosnap_ack", {29'b0, fl}, 32'b100);
    end
    rd_chk("cnt_nosnap", 32'h04, 32'h0001);

    resp_chk("rd_sh4", BASE + 32'h20, 1'b1, 3'b010);
    resp_chk("wr_sh0", BASE + 32'h10, 1'b0, 3'b010);
    resp_chk("rd_ctrl", BASE, 1'b1, 3'b010);
    resp_chk("wr_cnt", BASE + 32'h04, 1'b0, 3'b010);
    resp_chk("rd_unal", BASE + 32'h11, 1'b1, 3'b010);
    resp_chk("below_win", BASE - 4, 1'b1, 3'b000);
    resp_chk("above_win", HIGH + 1, 1'b1, 3'b000);

    capture(1, 32'h11);
    cd = '0; cd[1*DW +: DW] = 32'h22;
    snap("coinc_snap", 4'b0010, cd);
    rd_chk("coinc_old", 32'h14, 32'h11);
    snap("coinc_snap2", '0, '0);
    rd_chk("coinc_new", 32'h14, 32'h22);

    capture(2, 32'h01);
    capture(2, 32'h04);
    snap("acc_snap", '0, '0);
`ifdef OPB_STATUS_BANK_STICKY_EN
    rd_chk("acc_first", 32'h18, 32'h05);
    snap("acc_snap2", '0, '0);
    rd_chk("acc_second", 32'h18, 32'h00);
`else
    rd_chk("acc_first", 32'h18, 32'h04);
    snap("acc_snap2", '0, '0);
    rd_chk("acc_second", 32'h18, 32'h04);
`endif

    @(negedge clk);
    abus = BASE + 4; rnw_i = 1'b1; sel = 1'b1; acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (Sl_xferAck) acks++;
    end
    sel = 1'b0;
    chk("held_select", 32'(acks), 32'd2);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      valid = N'($urandom);
      for (int i = 0; i < N; i++) udata[i*DW +: DW] = $urandom;
      sel = ($urandom_range(0, 2) != 0);
      rnw_i = $urandom_range(0, 1);
      dbus = $urandom;
      case ($urandom_range(0, 7))
        0:       abus = BASE;
        1:       abus = BASE + 4;
        2, 3, 4: abus = BASE + 16 + 4 * $urandom_range(0, N + 1);
        5:       abus = BASE + $urandom_range(0, 255);
        6:       abus = ($urandom_range(0, 1) != 0) ? BASE - 4 : HIGH + 1;
        default: abus = BASE + 8;
      endcase
    end
    @(negedge clk);
    sel = 1'b0; valid = '0;
    @(negedge clk);
    @(negedge clk);

    // drive the counter up to 0xFFFF with a held CTRL SNAP write
    need = 65535 - m_cnt;
    abus = BASE; rnw_i = 1'b0; dbus = 32'h1; sel = (need > 0);
    acks = 0; cyc = 0;
    while (acks < need && cyc < 140000) begin
      @(negedge clk);
      cyc++;
      if (Sl_xferAck) acks++;
    end
    sel = 1'b0;
    chk("wrap_budget", 32'(acks), 32'(need));
    rd_chk("cnt_ffff", 32'h04, 32'h0000_FFFF);
    snap("wrap_snap", '0, '0);
    rd_chk("cnt_wrap", 32'h04, 32'h0000_0000);

    @(negedge clk);
    abus = BASE; rnw_i = 1'b0; dbus = 32'h1; sel = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_before_rst", {30'b0, Sl_xferAck, Sl_errAck}, 32'b10);
    rst_n = 1'b0;
    #1;
    chk("ack_dropped", {30'b0, Sl_xferAck, Sl_errAck}, 32'h0);
    chk("dbus_dropped", Sl_DBus, 32'h0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("cnt_after_rst", 32'h04, 32'h0000);
    rd_chk("sh0_after_rst", 32'h10, 32'h0000);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opb_status_bank.md
OPB_STATUS_BANK -- requirements
Module: opb_status_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0108EC00, base of the OPB window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0108ECFF, top of the OPB window.
REQ-003 SHALL have parameter C_NUM_CH, default 4, channel count; legal range 1..16.
REQ-004 SHALL have parameter C_DWIDTH, default 32, per-channel user width; legal range 1..32; zero-extended on read.
REQ-005 SHALL have port OPB_Clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port OPB_Rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port OPB_ABus, input, [0:31], address.
REQ-008 SHALL have port OPB_BE, input, [0:3], byte enables; ignored.
REQ-009 SHALL have port OPB_DBus, input, [0:31], write data.
REQ-010 SHALL have the following inputs, each 1 bit: OPB_RNW (1 = read), OPB_select (transfer request) and OPB_seqAddr (ignored).
REQ-011 SHALL have port Sl_DBus, output, [0:31], read data.
REQ-012 SHALL have the following outputs, each 1 bit: Sl_xferAck, Sl_errAck, Sl_retry and Sl_toutSup.
REQ-013 SHALL have port user_data_in, input, C_NUM_CH*C_DWIDTH, packed channel data; channel i occupies bits [i*C_DWIDTH +: C_DWIDTH].
REQ-014 SHALL have port user_valid, input, C_NUM_CH, per-channel capture strobe.

Function
REQ-015 Register map (byte offsets from C_BASEADDR; OPB bit 31 = LSB) SHALL be as follows:
- 0x00 CTRL: write-only; bit 31 = SNAP; reads return 0.
- 0x04 SNAPCNT: read-only; 16-bit snapshot counter in bits [16:31].
- 0x10+4*i SHADOW[i]: read-only, for i = 0..C_NUM_CH-1.
REQ-016 On each cycle with user_valid[i]=1, live[i] SHALL load channel i of user_data_in.
REQ-017 A write with OPB_DBus bit 31 = 1 to CTRL SHALL copy all live[i] into SHADOW[i] in the same cycle, and SHALL increment SNAPCNT by 1, wrapping 0xFFFF -> 0x0000.
REQ-018 When user_valid[i] and a snapshot occur in the same cycle, SHADOW[i] SHALL take the pre-update live[i], and live[i] SHALL take the new data.
REQ-019 The slave FSM SHALL use the states IDLE and ACK:
- IDLE -> ACK when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- ACK -> IDLE unconditionally.
REQ-020 In ACK, exactly one of Sl_xferAck or Sl_errAck SHALL be 1 for exactly one cycle; this gives a latency of 1 wait cycle after select.
REQ-021 Sl_errAck SHALL replace Sl_xferAck in the following cases:
- a write to any offset other than CTRL;
- a read of CTRL;
- any unmapped offset, including SHADOW[i] with i >= C_NUM_CH.
REQ-022 The address, RNW and write data SHALL be registered on the IDLE -> ACK transition, and the CTRL side effect SHALL occur in the ACK cycle.
REQ-023 Sl_DBus SHALL carry read data only in an ACK cycle with Sl_xferAck=1 and RNW=1, and SHALL be 32'h0 otherwise.
REQ-024 Sl_retry and Sl_toutSup SHALL be constant 0.
REQ-025 An out-of-window select SHALL produce no response, and the FSM SHALL remain in IDLE.
REQ-026 Back-to-back transfers SHALL be separated by at least one IDLE cycle, and a held OPB_select SHALL NOT re-acknowledge in the cycle following ACK.

Reset
REQ-027 While OPB_Rst_n=0, the following SHALL be held at reset values irrespective of OPB_Clk:
- the FSM SHALL be in IDLE;
- Sl_DBus, Sl_xferAck and Sl_errAck SHALL be 0;
- all live[i], SHADOW[i] and SNAPCNT SHALL be 0.
REQ-028 A reset asserted during ACK SHALL drop the acknowledge immediately, and the transfer SHALL NOT complete.
REQ-029 Deassertion SHALL be synchronised to OPB_Clk, and the first acknowledge SHALL be possible no earlier than the second rising edge after release.

Configuration
REQ-030 With OPB_STATUS_BANK_STICKY_EN defined, the following SHALL apply:
- user_valid[i] SHALL OR the channel data into live[i];
- a snapshot SHALL clear live[i] to 0 after copying;
- when capture and snapshot coincide, live[i] SHALL equal the new data alone.
REQ-031 Without OPB_STATUS_BANK_STICKY_EN, live[i] SHALL be overwritten per REQ-016 and SHALL NOT be cleared by a snapshot.

Verification
REQ-032 Reset, then valid[0] with data 0xA5A5_0001, then write CTRL=0x1, then read offset 0x10 -> 0xA5A50001 with Sl_xferAck exactly one cycle after select; SNAPCNT reads 0x0001.
REQ-033 C_NUM_CH=4: read offset 0x20 -> Sl_errAck one cycle, Sl_xferAck=0, Sl_DBus=0; write offset 0x10 -> Sl_errAck.
REQ-034 SNAPCNT preloaded by 65535 snapshots, one further snapshot -> SNAPCNT reads 0x0000.
REQ-035 valid[1] with 0x22 coincident with the snapshot while live[1]=0x11 -> SHADOW[1]=0x11; the next snapshot gives 0x22 (non-sticky) or 0x22 (sticky, live cleared to 0x22 only).
REQ-036 Sticky build: valid 0x01, then 0x04, then snapshot -> SHADOW=0x05; a second snapshot with no valid -> SHADOW=0x00.
REQ-037 OPB_Rst_n pulled low in the ACK cycle -> Sl_xferAck=0 in the same cycle; after release, read SNAPCNT -> 0x0000.
